dmem_access_ctrl: RTL and testbench
===================================

# dmem_access_ctrl

Sequencer and arbiter in front of the word-organised data memory. Shares the memory between two requesters: the core load/store path (port C) and the debug/program-loader port (port D). Every memory access is word-sized and word-aligned. Byte and halfword loads are extracted and extended here. Byte and halfword stores are performed as read-modify-write, so the memory only ever sees full-word writes.

## Interface
Parameters:
- DM_ADDRESS, 9, byte-address width; the word index is addr[DM_ADDRESS-1:2]
- DATA_W, 32, data width (only 32 supported)
- MAX_WAIT, 4, consecutive port-C grants allowed while port D waits; range 1..15

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high
- c_req / d_req  input  1  request valid; held stable with its fields until the matching ack
- c_we / d_we  input  1  1 = store, 0 = load
- c_addr / d_addr  input  DM_ADDRESS  byte address
- c_wd / d_wd  input  DATA_W  store data, right-aligned
- c_funct3 / d_funct3  input  3  RV32I width code: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
- c_ack / d_ack  output  1  one-cycle completion pulse
- c_err / d_err  output  1  valid with ack; misaligned access or illegal funct3
- c_rd / d_rd  output  DATA_W  load result, valid with ack; 0 on stores and errors
- mem_read  output  1  memory read enable
- mem_write  output  1  memory write enable
- mem_addr  output  DM_ADDRESS  word-aligned address {addr[DM_ADDRESS-1:2], 2'b00}
- mem_funct3  output  3  constant 3'b010
- mem_wd  output  DATA_W  full write word
- mem_rd  input  DATA_W  read word; valid the cycle after mem_read is asserted

## Operation
- FSM states: IDLE, RD, MERGE, WR, RESP.
- In IDLE, arbitration happens when any req is high.
  - Port C wins unless d_req is high and starve_cnt == MAX_WAIT; then port D wins.
  - Only one requester: it wins.
- Winning request fields are latched into internal registers; the port input fields are ignored until ack.
- Starvation counter:
  - starve_cnt increments when C is granted while d_req is high.
  - It clears on any D grant and whenever d_req is low in IDLE.
  - It saturates at MAX_WAIT.
- Error check at grant; an error goes straight to RESP with err=1, rd=0 and no memory access.
  - Halfword access with addr[0]=1 is an error.
  - Word access with addr[1:0]!=0 is an error.
  - funct3 011/110/111, or 100/101 with we=1, is an error.
- Load: IDLE -> RD -> RESP.
  - In RD, mem_read=1.
  - In RESP, mem_rd is shifted right by 8*addr[1:0] and extended: LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- SW: IDLE -> WR -> RESP. In WR, mem_write=1 and mem_wd = wd.
- SB/SH: IDLE -> RD -> MERGE -> WR -> RESP.
  - MERGE captures mem_rd.
  - The merged word replaces only the byte lanes selected by addr[1:0] and the width, taking wd[7:0] or wd[15:0] shifted to those lanes.
  - WR writes the merged word.
- RESP: the granted port's ack=1 for exactly one cycle, then the FSM returns to IDLE. The other port's ack, err and rd stay 0.
- mem_read and mem_write are never high in the same cycle. Both are 0 outside RD and WR.
- A requester deasserts req in the cycle after ack or presents a new transaction. A req seen high in IDLE is always treated as a new request.

## Timing
- Reset values:
  - State IDLE, starve_cnt=0.
  - All ack, err, mem_read and mem_write are 0.
  - c_rd, d_rd, mem_wd and mem_addr are 0.
- Reset mid-transaction aborts it: no ack is issued, and a write not yet in WR is never issued.
- Latency from req high in IDLE (cycle 0) to the ack cycle:
  - Error: ack in cycle 1.
  - SW: ack in cycle 2.
  - Load: ack in cycle 2.
  - SB/SH: ack in cycle 4.
- Back-to-back throughput: one new grant on the cycle after RESP.
- Simultaneous c_req and d_req with starve_cnt < MAX_WAIT: C is granted, D waits.
- A req asserted while the FSM is busy is held and arbitrated at the next IDLE.

## Test plan
- Word 0x20 = 0x8899AABB; C issues LB at 0x21 -> c_ack in cycle 2 with c_rd=0xFFFFFFAA. LBU at 0x21 -> 0x000000AA. LH at 0x22 -> 0xFFFF8899.
- C issues SB at 0x23 with wd=0x12 over 0x8899AABB -> mem_read in cycle 1, mem_write in cycle 3 with mem_addr=0x20 and mem_wd=0x1299AABB, c_ack in cycle 4.
- C issues LW at 0x06 -> c_ack and c_err in cycle 1, c_rd=0, no mem_read or mem_write. SH at 0x03 -> err. SB with funct3=100 -> err.
- c_req and d_req held continuously with MAX_WAIT=4 -> grant order C,C,C,C,D,C,C,C,C,D. starve_cnt clears after each D grant.
- D issues SW 0xDEADBEEF at 0x40, then LW at 0x40 -> d_rd=0xDEADBEEF. c_ack stays 0 throughout.
- reset asserted in MERGE of an SH -> no mem_write, no ack, all outputs 0 the next cycle, memory word unchanged.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dmem_access_ctrl
// Description : Sequencer and arbiter in front of a word-organised data
//               memory. Two requesters share the memory: port C (core
//               load/store path) and port D (debug / program loader).
//               Memory accesses are always full words. Byte and halfword
//               loads are extracted and extended here. Byte and halfword
//               stores are done as read-modify-write.
//
// Ports       : clk, reset              clock, synchronous active-high reset
//               c_* / d_*               request side: req, we, addr, wd,
//                                       funct3 in; ack, err, rd out
//               mem_read, mem_write     memory strobes (never both high)
//               mem_addr, mem_wd        word-aligned address, write word
//               mem_funct3              always word access (3'b010)
//               mem_rd                  read word, valid the cycle after
//                                       mem_read
// Revision    : 1.0  initial release
// ============================================================================
module dmem_access_ctrl #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  c_req,
    input  logic                  c_we,
    input  logic [DM_ADDRESS-1:0] c_addr,
    input  logic [DATA_W-1:0]     c_wd,
    input  logic [2:0]            c_funct3,
    output logic                  c_ack,
    output logic                  c_err,
    output logic [DATA_W-1:0]     c_rd,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [DM_ADDRESS-1:0] d_addr,
    input  logic [DATA_W-1:0]     d_wd,
    input  logic [2:0]            d_funct3,
    output logic                  d_ack,
    output logic                  d_err,
    output logic [DATA_W-1:0]     d_rd,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic [2:0]            mem_funct3,
    output logic [DATA_W-1:0]     mem_wd,
    input  logic [DATA_W-1:0]     mem_rd
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RD    = 3'd1;
    localparam logic [2:0] S_MERGE = 3'd2;
    localparam logic [2:0] S_WR    = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    localparam logic [3:0] C_MAX_WAIT = 4'(MAX_WAIT);
    localparam logic [2:0] C_F3_WORD  = 3'b010;

    logic [2:0]            r_state;
    logic [2:0]            w_next;
    logic                  r_sel_d;
    logic                  r_we;
    logic [DM_ADDRESS-1:0] r_addr;
    logic [DATA_W-1:0]     r_wd;
    logic [2:0]            r_f3;
    logic                  r_err;
    logic [3:0]            r_starve;
    logic [DATA_W-1:0]     r_word;

    // ------------------------------------------------------------------
    // Arbitration and request decode (only meaningful in IDLE)
    // ------------------------------------------------------------------
    logic                  w_any;
    logic                  w_grant_d;
    logic                  w_we;
    logic [DM_ADDRESS-1:0] w_addr;
    logic [2:0]            w_f3;
    logic                  w_err;

    assign w_any     = c_req | d_req;
    // D only wins over a live C request once it has waited MAX_WAIT grants.
    assign w_grant_d = d_req & (~c_req | (r_starve == C_MAX_WAIT));
    assign w_we      = w_grant_d ? d_we     : c_we;
    assign w_addr    = w_grant_d ? d_addr   : c_addr;
    assign w_f3      = w_grant_d ? d_funct3 : c_funct3;

    always_comb begin
        w_err = 1'b0;
        case (w_f3)
            3'b000:          w_err = 1'b0;
            3'b001:          w_err = w_addr[0];
            3'b010:          w_err = |w_addr[1:0];
            3'b100:          w_err = w_we;
            3'b101:          w_err = w_we | w_addr[0];
            default:         w_err = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    if (w_err)                 w_next = S_RESP;
                    else if (!w_we)            w_next = S_RD;
                    else if (w_f3 == C_F3_WORD) w_next = S_WR;
                    else                       w_next = S_RD;
                end
            end
            S_RD:    w_next = r_we ? S_MERGE : S_RESP;
            S_MERGE: w_next = S_WR;
            S_WR:    w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Lane shifting for sub-word loads and stores
    // ------------------------------------------------------------------
    logic [4:0]        w_lane_sh;
    logic [DATA_W-1:0] w_mask;
    logic [DATA_W-1:0] w_ins;
    logic [DATA_W-1:0] w_merged;
    logic [DATA_W-1:0] w_shifted;
    logic [DATA_W-1:0] w_load;

    assign w_lane_sh = {r_addr[1:0], 3'b000};
    // funct3[0] distinguishes halfword (SH) from byte (SB).
    assign w_mask    = (r_f3[0] ? 32'h0000_FFFF : 32'h0000_00FF) << w_lane_sh;
    assign w_ins     = (r_f3[0] ? {16'h0000, r_wd[15:0]} : {24'h000000, r_wd[7:0]}) << w_lane_sh;
    assign w_merged  = (mem_rd & ~w_mask) | (w_ins & w_mask);
    assign w_shifted = mem_rd >> w_lane_sh;

    always_comb begin
        w_load = w_shifted;
        case (r_f3)
            3'b000:  w_load = {{24{w_shifted[7]}},  w_shifted[7:0]};
            3'b001:  w_load = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b100:  w_load = {24'h000000, w_shifted[7:0]};
            3'b101:  w_load = {16'h0000,   w_shifted[15:0]};
            default: w_load = w_shifted;
        endcase
    end

    // ------------------------------------------------------------------
    // State and transaction registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_sel_d  <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wd     <= '0;
            r_f3     <= 3'b000;
            r_err    <= 1'b0;
            r_starve <= 4'd0;
            r_word   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE) begin
                if (w_any) begin
                    r_sel_d <= w_grant_d;
                    r_we    <= w_we;
                    r_addr  <= w_addr;
                    r_wd    <= w_grant_d ? d_wd : c_wd;
                    r_f3    <= w_f3;
                    r_err   <= w_err;
                end
                if (!d_req || w_grant_d)
                    r_starve <= 4'd0;
                else if (r_starve != C_MAX_WAIT)
                    r_starve <= r_starve + 4'd1;
            end
            if (r_state == S_MERGE)
                r_word <= w_merged;
        end
    end

    // ------------------------------------------------------------------
    // Outputs, decoded from state so they are all zero outside their slot
    // ------------------------------------------------------------------
    logic              w_resp;
    logic              w_mem_act;
    logic [DATA_W-1:0] w_rd_val;

    assign w_resp    = (r_state == S_RESP);
    assign w_mem_act = (r_state == S_RD) || (r_state == S_WR);
    assign w_rd_val  = (w_resp && !r_err && !r_we) ? w_load : '0;

    assign c_ack = w_resp & ~r_sel_d;
    assign d_ack = w_resp &  r_sel_d;
    assign c_err = c_ack & r_err;
    assign d_err = d_ack & r_err;
    assign c_rd  = c_ack ? w_rd_val : '0;
    assign d_rd  = d_ack ? w_rd_val : '0;

    assign mem_read   = (r_state == S_RD);
    assign mem_write  = (r_state == S_WR);
    assign mem_funct3 = C_F3_WORD;
    assign mem_addr   = w_mem_act ? {r_addr[DM_ADDRESS-1:2], 2'b00} : '0;
    assign mem_wd     = (r_state == S_WR) ? ((r_f3 == C_F3_WORD) ? r_wd : r_word) : '0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_access_ctrl
// Description : Directed self-checking bench for dmem_access_ctrl with a
//               behavioural word memory attached to the memory port.
// Revision    : 1.0  initial release
// ============================================================================
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        c_req, c_we, d_req, d_we;
    logic [8:0]  c_addr, d_addr;
    logic [31:0] c_wd, d_wd;
    logic [2:0]  c_funct3, d_funct3;
    logic        c_ack, c_err, d_ack, d_err;
    logic [31:0] c_rd, d_rd;
    logic        mem_read, mem_write;
    logic [8:0]  mem_addr;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_access_ctrl #(.DM_ADDRESS(9), .DATA_W(32), .MAX_WAIT(4)) dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wd(c_wd), .c_funct3(c_funct3),
        .c_ack(c_ack), .c_err(c_err), .c_rd(c_rd),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wd(d_wd), .d_funct3(d_funct3),
        .d_ack(d_ack), .d_err(d_err), .d_rd(d_rd),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_funct3(mem_funct3), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    // Behavioural word memory: synchronous write, registered read data.
    logic [31:0] mem [0:127];
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[8:2]] <= mem_wd;
        if (mem_read)  mem_rd <= mem[mem_addr[8:2]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction on port C (pd=0) or D (pd=1); cycle 0 is the
    // cycle the request is first seen in IDLE.
    task automatic txn(input string tag, input bit pd, input bit we, input logic [8:0] addr,
                       input logic [31:0] wd, input logic [2:0] f3, input int exp_lat,
                       input logic [31:0] exp_rd, input bit exp_err,
                       input logic [7:0] exp_rm, input logic [7:0] exp_wm,
                       input logic [31:0] exp_wdata);
        int          lat;
        logic [7:0]  rm, wm;
        logic [31:0] got_rd, last_wd;
        logic [8:0]  last_wa;
        bit          got_err, other, both;
        lat = -1; rm = '0; wm = '0; got_rd = '0; got_err = 1'b0;
        last_wd = '0; last_wa = '0; other = 1'b0; both = 1'b0;
        if (pd) begin d_req = 1; d_we = we; d_addr = addr; d_wd = wd; d_funct3 = f3; end
        else    begin c_req = 1; c_we = we; c_addr = addr; c_wd = wd; c_funct3 = f3; end
        for (int cyc = 0; cyc < 8 && lat < 0; cyc++) begin
            if (cyc > 0) tick();
            if (mem_read) rm[cyc] = 1'b1;
            if (mem_write) begin wm[cyc] = 1'b1; last_wd = mem_wd; last_wa = mem_addr; end
            if (mem_read && mem_write) both = 1'b1;
            if (pd ? c_ack : d_ack) other = 1'b1;
            if (pd ? d_ack : c_ack) begin
                lat     = cyc;
                got_rd  = pd ? d_rd  : c_rd;
                got_err = pd ? d_err : c_err;
            end
        end
        c_req = 0; d_req = 0;
        tick();
        chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, ".rd"},      got_rd,   exp_rd);
        chk({tag, ".err"},     32'(got_err), 32'(exp_err));
        chk({tag, ".rd_cyc"},  32'(rm),  32'(exp_rm));
        chk({tag, ".wr_cyc"},  32'(wm),  32'(exp_wm));
        chk({tag, ".other_ack"}, 32'(other), 32'd0);
        chk({tag, ".rd_and_wr"}, 32'(both),  32'd0);
        if (exp_wm != 8'd0) begin
            chk({tag, ".wr_addr"}, 32'(last_wa), 32'({addr[8:2], 2'b00}));
            chk({tag, ".wr_data"}, last_wd, exp_wdata);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog simulation time limit exceeded");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [9:0] order;
        int         ngrant;
        bit         seen_wr;
        reset = 1; c_req = 0; d_req = 0; c_we = 0; d_we = 0;
        c_addr = '0; d_addr = '0; c_wd = '0; d_wd = '0; c_funct3 = 3'b010; d_funct3 = 3'b010;
        tick(); tick();
        chk("rst.c_ack", 32'(c_ack), 0);
        chk("rst.d_ack", 32'(d_ack), 0);
        chk("rst.c_err", 32'(c_err), 0);
        chk("rst.mem_read", 32'(mem_read), 0);
        chk("rst.mem_write", 32'(mem_write), 0);
        chk("rst.c_rd", c_rd, 0);
        chk("rst.mem_wd", mem_wd, 0);
        chk("rst.mem_addr", 32'(mem_addr), 0);
        chk("rst.mem_funct3", 32'(mem_funct3), 32'd2);
        reset = 0;
        tick();

        // Word store then sub-word loads of 0x8899AABB at 0x20
        txn("sw20",  0, 1, 9'h020, 32'h8899AABB, 3'b010, 2, 32'h0, 0, 8'h00, 8'h02, 32'h8899AABB);
        txn("lb21",  0, 0, 9'h021, 32'h0, 3'b000, 2, 32'hFFFFFFAA, 0, 8'h02, 8'h00, 32'h0);
        txn("lbu21", 0, 0, 9'h021, 32'h0, 3'b100, 2, 32'h000000AA, 0, 8'h02, 8'h00, 32'h0);
        txn("lh22",  0, 0, 9'h022, 32'h0, 3'b001, 2, 32'hFFFF8899, 0, 8'h02, 8'h00, 32'h0);
        txn("lhu22", 0, 0, 9'h022, 32'h0, 3'b101, 2, 32'h00008899, 0, 8'h02, 8'h00, 32'h0);
        txn("lw20",  0, 0, 9'h020, 32'h0, 3'b010, 2, 32'h8899AABB, 0, 8'h02, 8'h00, 32'h0);

        // Read-modify-write stores
        txn("sb23",  0, 1, 9'h023, 32'h00000012, 3'b000, 4, 32'h0, 0, 8'h02, 8'h08, 32'h1299AABB);
        txn("lw20b", 0, 0, 9'h020, 32'h0, 3'b010, 2, 32'h1299AABB, 0, 8'h02, 8'h00, 32'h0);
        txn("sh20",  0, 1, 9'h020, 32'hFFFF5566, 3'b001, 4, 32'h0, 0, 8'h02, 8'h08, 32'h12995566);
        txn("lb20",  0, 0, 9'h020, 32'h0, 3'b000, 2, 32'h00000066, 0, 8'h02, 8'h00, 32'h0);

        // Error cases: no memory access, ack in cycle 1
        txn("lw06err", 0, 0, 9'h006, 32'h0, 3'b010, 1, 32'h0, 1, 8'h00, 8'h00, 32'h0);
        txn("sh03err", 0, 1, 9'h003, 32'h5555, 3'b001, 1, 32'h0, 1, 8'h00, 8'h00, 32'h0);
        txn("sbuerr",  0, 1, 9'h020, 32'h77, 3'b100, 1, 32'h0, 1, 8'h00, 8'h00, 32'h0);
        txn("f3err",   0, 0, 9'h020, 32'h0, 3'b011, 1, 32'h0, 1, 8'h00, 8'h00, 32'h0);
        txn("lw20c",   0, 0, 9'h020, 32'h0, 3'b010, 2, 32'h12995566, 0, 8'h02, 8'h00, 32'h0);

        // Port D traffic
        txn("dsw40", 1, 1, 9'h040, 32'hDEADBEEF, 3'b010, 2, 32'h0, 0, 8'h00, 8'h02, 32'hDEADBEEF);
        txn("dlw40", 1, 0, 9'h040, 32'h0, 3'b010, 2, 32'hDEADBEEF, 0, 8'h02, 8'h00, 32'h0);

        // Both ports requesting continuously: starvation-limited alternation
        c_we = 0; c_addr = 9'h020; c_funct3 = 3'b010;
        d_we = 0; d_addr = 9'h040; d_funct3 = 3'b010;
        c_req = 1; d_req = 1;
        order = '0; ngrant = 0;
        for (int cyc = 0; cyc < 80 && ngrant < 10; cyc++) begin
            tick();
            if (c_ack && d_ack) chk("arb.both_ack", 32'd1, 32'd0);
            if (d_ack) begin order[ngrant] = 1'b1; ngrant++; end
            else if (c_ack) ngrant++;
        end
        c_req = 0; d_req = 0;
        tick();
        chk("arb.grants", 32'(ngrant), 32'd10);
        chk("arb.order", 32'(order), 32'(10'b10_0001_0000));

        // Reset during MERGE of a halfword store must abort it
        seen_wr = 0;
        c_req = 1; c_we = 1; c_addr = 9'h040; c_wd = 32'h00001234; c_funct3 = 3'b001;
        tick();
        chk("abort.rd_c1", 32'(mem_read), 32'd1);
        tick();
        if (mem_write) seen_wr = 1;
        reset = 1;
        tick();
        if (mem_write) seen_wr = 1;
        chk("abort.no_write", 32'(seen_wr), 0);
        chk("abort.c_ack", 32'(c_ack), 0);
        chk("abort.mem_read", 32'(mem_read), 0);
        chk("abort.mem_wd", mem_wd, 0);
        chk("abort.mem_addr", 32'(mem_addr), 0);
        chk("abort.c_rd", c_rd, 0);
        c_req = 0; reset = 0;
        tick();
        txn("dlw40b", 1, 0, 9'h040, 32'h0, 3'b010, 2, 32'hDEADBEEF, 0, 8'h02, 8'h00, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
